// File: rtl/vc_sram_1r1w_pipe.sv
// rtl/vc_sram_1r1w_pipe.sv - 1R1W synchronous RAM with lane write enables and a 1/2-cycle read pipeline
module vc_sram_1r1w_pipe #(
  parameter int p_mem_sz   = 32,
  parameter int p_data_sz  = 32,
  parameter int p_lane_sz  = 8,
  parameter int p_rd_lat   = 1,
  parameter int p_rdw_mode = 0,
  localparam int c_addr_sz   = $clog2(p_mem_sz),
  localparam int c_num_lanes = (p_data_sz + p_lane_sz - 1) / p_lane_sz
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   wr_en,
  input  logic [c_addr_sz-1:0]   wr_addr,
  input  logic [c_num_lanes-1:0] wr_lane_en,
  input  logic [p_data_sz-1:0]   wr_data,
  input  logic                   rd_en,
  input  logic [c_addr_sz-1:0]   rd_addr,
  output logic                   rd_val,
  output logic [p_data_sz-1:0]   rd_data
);

  localparam logic [c_addr_sz:0] c_mem_lim = (c_addr_sz + 1)'(p_mem_sz);

  logic [p_data_sz-1:0] mem [p_mem_sz];
  logic [p_data_sz-1:0] wr_mask;
  logic                 wr_ok;
  logic                 rd_ok;
  logic                 rdw_hit;
  logic [p_data_sz-1:0] rd_old;
  logic [p_data_sz-1:0] rd_word;

  // Expand lane enables to a per-bit mask; the top lane may be narrower.
  for (genvar b = 0; b < p_data_sz; b++) begin : g_mask
    assign wr_mask[b] = wr_lane_en[b / p_lane_sz];
  end

  assign wr_ok   = wr_en && ({1'b0, wr_addr} < c_mem_lim);
  assign rd_ok   = ({1'b0, rd_addr} < c_mem_lim);
  assign rdw_hit = (p_rdw_mode == 1) && wr_ok && (wr_addr == rd_addr);

  // Storage is deliberately left out of reset so contents survive it.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_addr] <= (mem[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
    end
  end

  assign rd_old = rd_ok ? mem[rd_addr] : '0;

  always_comb begin
    rd_word = rd_old;
    if (rdw_hit) begin
      rd_word = (rd_old & ~wr_mask) | (wr_data & wr_mask);
    end
  end

  if (p_rd_lat == 1) begin : g_lat1
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rd_val  <= 1'b0;
        rd_data <= '0;
      end else begin
        rd_val <= rd_en;
        if (rd_en) begin
          rd_data <= rd_word;
        end
      end
    end
  end else if (p_rd_lat == 2) begin : g_lat2
    logic                 s1_val;
    logic [p_data_sz-1:0] s1_data;

    // Stage 1 snapshots the word, so later writes cannot disturb an in-flight read.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        s1_val  <= 1'b0;
        s1_data <= '0;
        rd_val  <= 1'b0;
        rd_data <= '0;
      end else begin
        s1_val <= rd_en;
        if (rd_en) begin
          s1_data <= rd_word;
        end
        rd_val <= s1_val;
        if (s1_val) begin
          rd_data <= s1_data;
        end
      end
    end
  end else begin : g_bad_lat
    $error("vc_sram_1r1w_pipe: p_rd_lat must be 1 or 2");
  end

endmodule

// File: tb/tb_vc_sram_1r1w_pipe.sv
// tb/tb_vc_sram_1r1w_pipe.sv - randomized bench for vc_sram_1r1w_pipe against a behavioural model
module tb_vc_sram_1r1w_pipe;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic        a_wr_en, a_rd_en, a_rd_val;
  logic [4:0]  a_wr_addr, a_rd_addr;
  logic [3:0]  a_wr_lane_en;
  logic [31:0] a_wr_data, a_rd_data;

  logic        b_wr_en, b_rd_en, b_rd_val;
  logic [4:0]  b_wr_addr, b_rd_addr;
  logic [3:0]  b_wr_lane_en;
  logic [31:0] b_wr_data, b_rd_data;

  logic        c_wr_en, c_rd_en, c_rd_val;
  logic [4:0]  c_wr_addr, c_rd_addr;
  logic [2:0]  c_wr_lane_en;
  logic [19:0] c_wr_data, c_rd_data;

  vc_sram_1r1w_pipe u_a (
    .clk(clk), .reset_n(reset_n),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_lane_en(a_wr_lane_en), .wr_data(a_wr_data),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_val(a_rd_val), .rd_data(a_rd_data)
  );

  vc_sram_1r1w_pipe #(.p_rd_lat(2), .p_rdw_mode(1)) u_b (
    .clk(clk), .reset_n(reset_n),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_lane_en(b_wr_lane_en), .wr_data(b_wr_data),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_val(b_rd_val), .rd_data(b_rd_data)
  );

  vc_sram_1r1w_pipe #(.p_mem_sz(24), .p_data_sz(20)) u_c (
    .clk(clk), .reset_n(reset_n),
    .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_lane_en(c_wr_lane_en), .wr_data(c_wr_data),
    .rd_en(c_rd_en), .rd_addr(c_rd_addr), .rd_val(c_rd_val), .rd_data(c_rd_data)
  );

  localparam int n_inst = 3;
  int sz   [n_inst] = '{32, 32, 24};
  int dw   [n_inst] = '{32, 32, 20};
  int lat  [n_inst] = '{1, 2, 1};
  int mode [n_inst] = '{0, 1, 0};

  typedef struct {
    bit          we;
    int          wa;
    int          le;
    logic [31:0] wd;
    bit          re;
    int          ra;
  } req_t;

  typedef struct {
    int          k;
    int          due;
    logic [31:0] d;
  } rsp_t;

  logic [31:0] ref_mem [n_inst][32];
  logic [31:0] last_d  [n_inst];
  rsp_t        pend [$];
  req_t        rq   [n_inst];
  int          cyc, total, bad;

  logic        got_val  [n_inst];
  logic [31:0] got_data [n_inst];
  assign got_val[0]  = a_rd_val;
  assign got_val[1]  = b_rd_val;
  assign got_val[2]  = c_rd_val;
  assign got_data[0] = a_rd_data;
  assign got_data[1] = b_rd_data;
  assign got_data[2] = {12'b0, c_rd_data};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clr();
    for (int k = 0; k < n_inst; k++) rq[k] = '{default: 0};
  endtask

  task automatic drive();
    a_wr_en = rq[0].we; a_wr_addr = 5'(rq[0].wa); a_wr_lane_en = 4'(rq[0].le);
    a_wr_data = rq[0].wd; a_rd_en = rq[0].re; a_rd_addr = 5'(rq[0].ra);
    b_wr_en = rq[1].we; b_wr_addr = 5'(rq[1].wa); b_wr_lane_en = 4'(rq[1].le);
    b_wr_data = rq[1].wd; b_rd_en = rq[1].re; b_rd_addr = 5'(rq[1].ra);
    c_wr_en = rq[2].we; c_wr_addr = 5'(rq[2].wa); c_wr_lane_en = 3'(rq[2].le);
    c_wr_data = rq[2].wd[19:0]; c_rd_en = rq[2].re; c_rd_addr = 5'(rq[2].ra);
  endtask

  function automatic logic [31:0] lane_mask(input int k, input int le);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < dw[k]; b++) if (le[b / 8]) m[b] = 1'b1;
    return m;
  endfunction

  // Reference: responses are queued with the cycle they are due at.
  task automatic model_cycle();
    for (int k = 0; k < n_inst; k++) begin
      logic [31:0] m, old, rsp;
      bit wok;
      m   = lane_mask(k, rq[k].le);
      wok = rq[k].we && (rq[k].wa < sz[k]);
      if (rq[k].re) begin
        old = (rq[k].ra < sz[k]) ? ref_mem[k][rq[k].ra] : 32'h0;
        rsp = old;
        if (mode[k] == 1 && wok && rq[k].wa == rq[k].ra) rsp = (old & ~m) | (rq[k].wd & m);
        pend.push_back('{k, cyc + lat[k], rsp});
      end
      if (wok) ref_mem[k][rq[k].wa] = (ref_mem[k][rq[k].wa] & ~m) | (rq[k].wd & m);
    end
  endtask

  task automatic edge_check();
    @(posedge clk);
    cyc++;
    #1;
    for (int k = 0; k < n_inst; k++) begin
      bit hit;
      logic [31:0] ed;
      hit = 1'b0;
      ed  = last_d[k];
      for (int i = 0; i < pend.size(); i++) begin
        if (!hit && pend[i].k == k && pend[i].due == cyc) begin
          hit = 1'b1;
          ed  = pend[i].d;
          pend.delete(i);
        end
      end
      last_d[k] = ed;
      chk($sformatf("val%0d_c%0d", k, cyc), {31'b0, got_val[k]}, {31'b0, hit});
      chk($sformatf("data%0d_c%0d", k, cyc), got_data[k], ed);
    end
  endtask

  task automatic apply();
    @(negedge clk);
    drive();
    model_cycle();
    edge_check();
  endtask

  task automatic set_wr(input int k, input int a, input int le, input logic [31:0] d);
    rq[k].we = 1'b1; rq[k].wa = a; rq[k].le = le; rq[k].wd = d;
  endtask

  task automatic set_rd(input int k, input int a);
    rq[k].re = 1'b1; rq[k].ra = a;
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0;
    for (int k = 0; k < n_inst; k++) begin
      last_d[k] = '0;
      for (int a = 0; a < 32; a++) ref_mem[k][a] = '0;
    end
    clr();
    drive();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < n_inst; k++) begin
      chk($sformatf("rst_val%0d", k), {31'b0, got_val[k]}, 32'h0);
      chk($sformatf("rst_data%0d", k), got_data[k], 32'h0);
    end
    @(negedge clk);
    reset_n = 1'b1;

    // Preload addr i = i; c also sees dropped out-of-range writes at 24..31.
    for (int i = 0; i < 32; i++) begin
      clr();
      for (int k = 0; k < n_inst; k++) set_wr(k, i, 15, 32'(i));
      apply();
    end

    // Streaming reads 0..3 on every instance.
    for (int i = 0; i < 4; i++) begin
      clr();
      for (int k = 0; k < n_inst; k++) set_rd(k, i);
      apply();
    end
    clr();
    repeat (3) apply();

    clr(); set_wr(0, 5, 15, 32'hDEADBEEF); set_wr(1, 5, 15, 32'hDEADBEEF); apply();
    clr(); set_rd(0, 5); set_rd(1, 5); apply();
    chk("t1_val_a", {31'b0, got_val[0]}, 32'h1);
    chk("t1_a", got_data[0], 32'hDEADBEEF);
    clr(); apply();
    chk("t1_b", got_data[1], 32'hDEADBEEF);

    clr(); set_wr(0, 5, 5, 32'h11223344); set_wr(1, 5, 5, 32'h11223344); apply();
    clr(); set_rd(0, 5); set_rd(1, 5); apply();
    chk("t2_a", got_data[0], 32'hDE22BE44);
    clr(); apply();
    chk("t2_b", got_data[1], 32'hDE22BE44);

    clr(); set_wr(0, 3, 15, 32'hAAAAAAAA); set_wr(1, 3, 15, 32'hAAAAAAAA); apply();
    clr();
    set_wr(0, 3, 3, 32'h55555555); set_rd(0, 3);
    set_wr(1, 3, 3, 32'h55555555); set_rd(1, 3);
    apply();
    chk("t3_old_a", got_data[0], 32'hAAAAAAAA);
    clr(); apply();
    chk("t3_fwd_b", got_data[1], 32'hAAAA5555);
    clr(); set_rd(0, 3); set_rd(1, 3); apply();
    chk("t3_follow_a", got_data[0], 32'hAAAA5555);
    clr(); apply();
    chk("t3_follow_b", got_data[1], 32'hAAAA5555);

    clr(); set_wr(2, 26, 7, 32'hFFFFF); apply();
    clr(); set_rd(2, 26); apply();
    chk("t6_oor_val", {31'b0, got_val[2]}, 32'h1);
    chk("t6_oor_data", got_data[2], 32'h0);
    clr(); set_wr(2, 23, 4, 32'hFFFFF); apply();
    clr(); set_rd(2, 23); apply();
    chk("t6_lane", got_data[2], 32'h000F0017);

    // Reset pulse while b's read of addr 7 is in stage 1.
    clr(); set_rd(1, 7); apply();
    clr(); drive();
    reset_n = 1'b0;
    #1;
    for (int k = 0; k < n_inst; k++) begin
      chk($sformatf("midrst_val%0d", k), {31'b0, got_val[k]}, 32'h0);
      chk($sformatf("midrst_data%0d", k), got_data[k], 32'h0);
      last_d[k] = '0;
    end
    pend.delete();
    @(negedge clk);
    reset_n = 1'b1;
    edge_check();
    edge_check();
    clr(); set_rd(1, 7); apply();
    clr(); apply();
    chk("t5_reread", got_data[1], 32'h7);

    for (int n = 0; n < 400; n++) begin
      clr();
      for (int k = 0; k < n_inst; k++) begin
        rq[k].we = 1'($urandom_range(0, 1));
        rq[k].wa = $urandom_range(0, 31);
        rq[k].le = $urandom_range(0, 15);
        rq[k].wd = $urandom;
        rq[k].re = ($urandom_range(0, 3) != 0);
        rq[k].ra = ($urandom_range(0, 2) == 0) ? rq[k].wa : $urandom_range(0, 31);
      end
      apply();
    end
    clr();
    repeat (3) apply();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
